// File: rtl/tdnn_tap_buffer.sv
// I/Q tap-delay buffer for a TDNN generator: FIFO-fed delay line plus a request/ack sequencer.
// A pop reaches out_valid 2 cycles later; s_ready drops when the FIFO is full and excess samples are dropped.
module tdnn_tap_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_WINDOW = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                s_i,
  input  logic [DATA_WIDTH-1:0]                s_q,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 flush,
  input  logic                                 gen_busy,
  output logic [DATA_WIDTH*2*NUM_TAPS-1:0]     out_vector,
  output logic                                 out_valid,
  output logic                                 primed,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill_level,
  output logic                                 overflow
);

  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TC_W   = $clog2(NUM_TAPS + 1);
  localparam int AC_W   = $clog2(ACK_WINDOW + 1);
  localparam logic [FILL_W-1:0] FIFO_FULL = FILL_W'(FIFO_DEPTH);
  localparam logic [TC_W-1:0]   TAPS_MAX  = TC_W'(NUM_TAPS);
  localparam logic [AC_W-1:0]   ACK_LAST  = AC_W'(ACK_WINDOW - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                    state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]         cnt_q;
  logic                      rdy_en_q;
  logic                      overflow_q;
  logic [2*DATA_WIDTH-1:0]   hold_q;
  logic [DATA_WIDTH-1:0]     tap_i_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0]     tap_q_q [NUM_TAPS];
  logic [TC_W-1:0]           tap_cnt_q, tap_cnt_d;
  logic [AC_W-1:0]           ack_cnt_q, ack_cnt_d;
  logic                      push, pop, fifo_empty;

  assign fifo_empty = (cnt_q == '0);
  // rdy_en_q keeps s_ready low until the first edge after reset is released.
  assign s_ready    = rdy_en_q && (cnt_q != FIFO_FULL);
  assign push       = s_valid && s_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty && !gen_busy;
  assign out_valid  = (state_q == ISSUE);
  assign primed     = (tap_cnt_q == TAPS_MAX);
  assign fill_level = cnt_q;
  assign overflow   = overflow_q;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
    assign out_vector[(2*NUM_TAPS-1-2*k)*DATA_WIDTH +: DATA_WIDTH] = tap_i_q[k];
    assign out_vector[(2*NUM_TAPS-2-2*k)*DATA_WIDTH +: DATA_WIDTH] = tap_q_q[k];
  end

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      IDLE:      if (pop) state_d = SHIFT;
      SHIFT: begin
        if (tap_cnt_q != TAPS_MAX) tap_cnt_d = tap_cnt_q + 1'b1;
        state_d = (tap_cnt_d == TAPS_MAX) ? ISSUE : IDLE;
      end
      ISSUE: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (gen_busy)                    state_d = WAIT_DONE;
        else if (ack_cnt_q == ACK_LAST)  state_d = IDLE;
        else                             ack_cnt_d = ack_cnt_q + 1'b1;
      end
      WAIT_DONE: if (!gen_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {s_i, s_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rdy_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
      tap_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_i_q[k] <= '0;
        tap_q_q[k] <= '0;
      end
    end else begin
      rdy_en_q <= 1'b1;
      if (flush) begin
        state_q    <= IDLE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        overflow_q <= 1'b0;
        tap_cnt_q  <= '0;
        ack_cnt_q  <= '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
          tap_i_q[k] <= '0;
          tap_q_q[k] <= '0;
        end
      end else begin
        state_q   <= state_d;
        tap_cnt_q <= tap_cnt_d;
        ack_cnt_q <= ack_cnt_d;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          hold_q   <= mem_q[rd_ptr_q];
        end
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        if (s_valid && !s_ready) overflow_q <= 1'b1;
        // Taps only move here, so the vector is frozen while a request is outstanding.
        if (state_q == SHIFT) begin
          for (int k = NUM_TAPS - 1; k > 0; k--) begin
            tap_i_q[k] <= tap_i_q[k-1];
            tap_q_q[k] <= tap_q_q[k-1];
          end
          tap_i_q[0] <= hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tap_q_q[0] <= hold_q[DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: doc/tdnn_tap_buffer.md
TDNN_TAP_BUFFER -- requirements
Module: tdnn_tap_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample word width, Q1.15 signed.
REQ-002 SHALL have parameter NUM_TAPS, default 9: I/Q delay-line depth; output vector holds 2*NUM_TAPS words (18 at default).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input sample FIFO entries, power of two.
REQ-004 SHALL have parameter ACK_WINDOW, default 4: cycles allowed for the consumer to raise busy after a request.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port s_i, input, DATA_WIDTH: incoming I sample, signed.
REQ-008 SHALL have port s_q, input, DATA_WIDTH: incoming Q sample, signed.
REQ-009 SHALL have port s_valid, input, 1: the sample pair is presented.
REQ-010 SHALL have port s_ready, output, 1: the FIFO can accept a sample this cycle.
REQ-011 SHALL have port flush, input, 1: synchronous clear of the FIFO, taps and sequencer.
REQ-012 SHALL have port gen_busy, input, 1: the downstream generator is busy.
REQ-013 SHALL have port out_vector, output, DATA_WIDTH*2*NUM_TAPS: packed tap vector sent to the generator.
REQ-014 SHALL have port out_valid, output, 1: one-cycle inference request to the generator.
REQ-015 SHALL have port primed, output, 1: all NUM_TAPS taps hold real samples.
REQ-016 SHALL have port fill_level, output, clog2(FIFO_DEPTH+1): current FIFO occupancy.
REQ-017 SHALL have port overflow, output, 1: sticky flag for a dropped sample.

Function
REQ-018 SHALL accept a sample when s_valid && s_ready; s_ready = (fill_level != FIFO_DEPTH).
REQ-019 SHALL, on s_valid && !s_ready, drop the sample, set overflow, and leave FIFO contents unchanged.
REQ-020 SHALL, on a push and pop in the same cycle, keep fill_level unchanged and preserve FIFO order.
REQ-021 SHALL pack out_vector newest-first: the top word is I(n), then Q(n), then I(n-1), Q(n-1), and so on; the lowest word is Q(n-NUM_TAPS+1).
REQ-022 SHALL implement a sequencer with the states IDLE, SHIFT, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-023 SHALL, in IDLE with the FIFO non-empty and gen_busy low, pop one sample and go to SHIFT; otherwise it stays in IDLE.
REQ-024 SHALL, in SHIFT, shift the popped pair into the tap line (oldest pair discarded) and increment the tap count, saturating at NUM_TAPS; it then goes to ISSUE if the count is NUM_TAPS, else to IDLE.
REQ-025 SHALL, in ISSUE, assert out_valid for exactly one cycle and go to WAIT_ACK.
REQ-026 SHALL, in WAIT_ACK, go to WAIT_DONE when gen_busy is high; if gen_busy stays low for ACK_WINDOW cycles, it goes to IDLE.
REQ-027 SHALL, in WAIT_DONE, go to IDLE when gen_busy is low.
REQ-028 SHALL hold out_vector stable from ISSUE until the next SHIFT; the taps never change while a request is outstanding.
REQ-029 SHALL, for a push at edge t into an empty FIFO with the sequencer in IDLE, gen_busy low and primed high, assert out_valid in the cycle following edge t+2.
REQ-030 SHALL drive primed = (tap count == NUM_TAPS); before priming, samples shift in but no request is issued.
REQ-031 SHALL pass data unmodified, with no arithmetic, saturation or rounding on samples.
REQ-032 SHALL, when flush is high, clear the FIFO, taps, tap count, overflow and sequencer (to IDLE) at the next edge, ignoring any simultaneous push.
REQ-033 SHALL, after a flush during WAIT_DONE, rely on the IDLE gen_busy check so that no request is issued while the generator is busy.

Reset
REQ-034 SHALL, while rst is high, immediately force: sequencer IDLE, FIFO empty, all taps 0, tap count 0, out_vector 0, out_valid 0, primed 0, fill_level 0, overflow 0.
REQ-035 SHALL drive s_ready at 0 while rst is high and at 1 from the first edge after rst is released.
REQ-036 SHALL abort any operation in progress when reset asserts mid-operation; no out_valid pulse is produced afterwards from pre-reset data.

Verification
REQ-037 SHALL cover priming: push 9 samples I=k*0x0100, Q=-k*0x0100 (k=1..9) with gen_busy=0 -> no out_valid for k<9; after k=9, a single out_valid and primed=1; top word 0x0900, lowest word 0xFF00.
REQ-038 SHALL cover the busy handshake: model gen_busy high 1 cycle after out_valid for 150 cycles, push a 10th sample -> no second out_valid until 1 cycle after gen_busy falls; out_vector is unchanged throughout.
REQ-039 SHALL cover overflow: hold gen_busy=1, push 6 samples back-to-back -> fill_level=4, s_ready=0, overflow=1; samples 5 and 6 are absent from later vectors.
REQ-040 SHALL cover ack timeout: keep gen_busy=0 permanently and issue a request -> the sequencer returns to IDLE after 4 cycles, and the next queued sample is issued.
REQ-041 SHALL cover flush and reset mid-operation: flush in WAIT_DONE -> primed=0, fill_level=0, overflow=0; async rst pulse mid-SHIFT -> all outputs are 0 without waiting for a clock edge.
